trade_frame_packer: RTL and testbench
=====================================

# trade_frame_packer

Feed-side companion of the trading signal generator. Collects a stream of 5-bit daily prices, packs three of them with the current ownership bit into the generator's 16-bit stock word, and presents it under a valid/ready handshake. Closes the loop by decoding the generator's 16-bit action code into a saturating share-position counter; that counter drives the ownership bit of the next word.

## Interface
- MAX_POS, 31: position saturation limit (≤ 2^POS_W−1)
- POS_W, 5: position counter width
- ACT_TIMEOUT, 16: cycles to wait for an action code before abandoning the frame
- SLIDING, 1: 1 = each new price after priming forms a frame (window of last 3); 0 = three fresh prices per frame
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- price_valid  in  1  price_in valid
- price_in  in  5  daily price
- price_ready  out  1  block accepts a price
- stock_out  out  16  {owned, day1[4:0], day2[4:0], day3[4:0]}; day1 is the oldest
- stock_valid  out  1  stock_out valid
- stock_ready  in  1  consumer accepts stock_out
- action_valid  in  1  action_in valid
- action_in  in  16  action code from the generator
- position  out  POS_W  current share position
- timeout_err  out  1  sticky; an action wait expired

## Operation
- States: FILL, SEND, WAIT_ACT. Reset state is FILL.
- FILL:
  - price_ready=1.
  - Each accepted price shifts the window: p0←p1, p1←p2, p2←price_in. fill_cnt saturates at 3.
  - When an accepted price makes fill_cnt=3, register stock_out={position!=0, p0, p1, p2} with the new price included. Set stock_valid=1 and go to SEND.
  - SLIDING=0: fill_cnt clears to 0 on entering SEND.
  - SLIDING=1: fill_cnt stays at 3, so every later accepted price forms a frame.
- SEND:
  - price_ready=0.
  - stock_out and stock_valid are held stable until stock_ready is high.
  - On handshake: stock_valid←0, go to WAIT_ACT, clear the timeout counter.
- WAIT_ACT:
  - price_ready=0.
  - On action_valid, update position and go to FILL.
  - If ACT_TIMEOUT cycles pass without action_valid: set timeout_err, leave position unchanged, go to FILL.
  - action_valid outside WAIT_ACT is ignored.
- Action decode (saturating, width POS_W):
  - 1 → 0
  - 2 and 8 → unchanged
  - 3 → +2
  - 4 → +4
  - 5 → floor(pos/2)
  - 6 and 7 → +1
  - Additions clamp at MAX_POS.
  - Code 0 and codes >8 leave position unchanged but still complete the frame.
- owned bit = (position != 0), sampled at frame formation.

## Timing
- Reset values:
  - stock_out=0, stock_valid=0, position=0, timeout_err=0.
  - price_ready=1 (FILL).
  - Window and fill_cnt cleared.
- Latency:
  - The third accepted price (cycle N) gives stock_valid=1 at N+1.
  - An action accepted at cycle M updates position at M+1, and price_ready=1 at M+1.
  - The earliest next frame forms from a price accepted at M+1, so it carries the updated owned bit.
- Timeout: the counter increments on each WAIT_ACT cycle without action_valid. It expires on the ACT_TIMEOUT-th such cycle: timeout_err=1 and state FILL on the next edge.
- Simultaneous events: action_valid on the expiry cycle wins; no error is set.
- Reset mid-operation: all state returns to reset values immediately. A partially filled window is discarded.
- timeout_err clears only on rst.

## Structure
- Shared package trade_pkg holds:
  - action code constants (ACT_NONE=0 … ACT_HOLD=8)
  - the frame state enum
  - stock word field offsets (OWNED_BIT=15, DAY1_LSB=10, DAY2_LSB=5, DAY3_LSB=0)
- One sub-module, position_tracker: action decode plus the saturating position register, with update enable, code input and position output.

## Test plan
- SLIDING=0, prices 10,12,15 after reset → stock_out=0x298F, stock_valid at cycle after 15; stock_ready=1 → WAIT_ACT.
- Action 4 → position=4. Then prices 20,18,17 → stock_out=0xD251 (owned=1).
- Saturation: position 30 with action 4 → 31; then action 5 → 15; then action 1 → 0. Codes 0 and 9 → no change.
- Backpressure: stock_ready low for 5 cycles with price_valid high → stock_out stable, price_ready=0, no prices consumed.
- Timeout: no action for 16 cycles → timeout_err=1, position unchanged, price_ready=1 next cycle. Action on cycle 16 → no error.
- SLIDING=1, prices 1,2,3,4 (action 2 between frames) → frames 0x0443 then 0x0864. Also assert rst mid-SEND → stock_valid=0 and the window must refill with 3 prices.

Source files
------------

// File: rtl/trade_frame_packer_pkg.sv
// Shared types for the trade frame packer: action codes, frame FSM states,
// stock word layout and a helper that assembles the stock word.
package trade_pkg;

  localparam logic [15:0] ACT_NONE  = 16'd0;
  localparam logic [15:0] ACT_EXIT  = 16'd1;
  localparam logic [15:0] ACT_KEEP  = 16'd2;
  localparam logic [15:0] ACT_BUY2  = 16'd3;
  localparam logic [15:0] ACT_BUY4  = 16'd4;
  localparam logic [15:0] ACT_HALVE = 16'd5;
  localparam logic [15:0] ACT_BUY1  = 16'd6;
  localparam logic [15:0] ACT_ADD1  = 16'd7;
  localparam logic [15:0] ACT_HOLD  = 16'd8;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACT = 2'd2
  } frame_state_t;

  localparam int OWNED_BIT = 15;
  localparam int DAY1_LSB  = 10;
  localparam int DAY2_LSB  = 5;
  localparam int DAY3_LSB  = 0;

  function automatic logic [15:0] pack_stock(
    input logic       owned,
    input logic [4:0] d1,
    input logic [4:0] d2,
    input logic [4:0] d3
  );
    logic [15:0] w;
    w = '0;
    w[OWNED_BIT]     = owned;
    w[DAY1_LSB +: 5] = d1;
    w[DAY2_LSB +: 5] = d2;
    w[DAY3_LSB +: 5] = d3;
    return w;
  endfunction

endpackage

// File: rtl/trade_frame_packer_if.sv
// Handshake bundle of the packer: price input, stock word output, action input.
// master = feed/generator side, slave = the packer.
interface trade_frame_packer_if;
  logic        price_valid;
  logic [4:0]  price_in;
  logic        price_ready;
  logic [15:0] stock_out;
  logic        stock_valid;
  logic        stock_ready;
  logic        action_valid;
  logic [15:0] action_in;

  modport master (
    output price_valid, price_in, stock_ready, action_valid, action_in,
    input  price_ready, stock_out, stock_valid
  );

  modport slave (
    input  price_valid, price_in, stock_ready, action_valid, action_in,
    output price_ready, stock_out, stock_valid
  );
endinterface

// File: rtl/trade_frame_packer_position_tracker.sv
// Decodes a 16-bit action code into a saturating share position update.
// Ports: clk, rst, en (apply code), code, pos (current position).
module position_tracker
  import trade_pkg::*;
#(
  parameter int POS_W   = 5,
  parameter int MAX_POS = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [15:0]      code,
  output logic [POS_W-1:0] pos
);

  logic [POS_W-1:0] inc;
  logic [POS_W:0]   sum;
  logic [POS_W-1:0] sat;
  logic [POS_W-1:0] nxt;

  always_comb begin
    inc = '0;
    unique case (1'b1)
      (code == ACT_BUY2): inc = POS_W'(2);
      (code == ACT_BUY4): inc = POS_W'(4);
      (code == ACT_BUY1),
      (code == ACT_ADD1): inc = POS_W'(1);
      default:            inc = '0;
    endcase
  end

  // One extra bit so the clamp sees the carry.
  assign sum = {1'b0, pos} + {1'b0, inc};
  assign sat = (sum > (POS_W+1)'(MAX_POS)) ?
               POS_W'(MAX_POS) : sum[POS_W-1:0];

  always_comb begin
    nxt = pos;
    unique case (1'b1)
      (code == ACT_EXIT):  nxt = '0;
      (code == ACT_HALVE): nxt = pos >> 1;
      (code == ACT_BUY2),
      (code == ACT_BUY4),
      (code == ACT_BUY1),
      (code == ACT_ADD1):  nxt = sat;
      default:             nxt = pos;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     pos <= '0;
    else if (en) pos <= nxt;
  end

endmodule

// File: rtl/trade_frame_packer.sv
// Packs 5-bit prices into 16-bit stock words and tracks position from actions.
// Ports: clk, rst, bus (slave handshake bundle), position, timeout_err.
module trade_frame_packer
  import trade_pkg::*;
#(
  parameter int MAX_POS     = 31,
  parameter int POS_W       = 5,
  parameter int ACT_TIMEOUT = 16,
  parameter int SLIDING     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  trade_frame_packer_if.slave  bus,
  output logic [POS_W-1:0]     position,
  output logic                 timeout_err
);

  localparam int TW = $clog2(ACT_TIMEOUT + 1);

  frame_state_t state;
  logic [1:0]    fill_cnt;
  // Oldest day is never needed after a frame: only the two newest are kept.
  logic [4:0]    w1;
  logic [4:0]    w2;
  logic [TW-1:0] tcnt;
  logic          act_en;

  assign act_en = (state == WAIT_ACT) && bus.action_valid;

  position_tracker #(
    .POS_W   (POS_W),
    .MAX_POS (MAX_POS)
  ) u_pos (
    .clk  (clk),
    .rst  (rst),
    .en   (act_en),
    .code (bus.action_in),
    .pos  (position)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= FILL;
      fill_cnt        <= '0;
      w1              <= '0;
      w2              <= '0;
      tcnt            <= '0;
      bus.stock_out   <= '0;
      bus.stock_valid <= 1'b0;
      bus.price_ready <= 1'b1;
      timeout_err     <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (bus.price_valid) begin
            w1 <= w2;
            w2 <= bus.price_in;
            if (fill_cnt >= 2'd2) begin
              bus.stock_out <= pack_stock(position != '0,
                                          w1, w2, bus.price_in);
              bus.stock_valid <= 1'b1;
              bus.price_ready <= 1'b0;
              state           <= SEND;
              fill_cnt <= (SLIDING != 0) ? 2'd3 : 2'd0;
            end else begin
              fill_cnt <= fill_cnt + 2'd1;
            end
          end
        end
        SEND: begin
          if (bus.stock_ready) begin
            bus.stock_valid <= 1'b0;
            tcnt            <= '0;
            state           <= WAIT_ACT;
          end
        end
        WAIT_ACT: begin
          // An action on the expiry cycle takes priority over the timeout.
          if (bus.action_valid) begin
            state           <= FILL;
            bus.price_ready <= 1'b1;
          end else if (tcnt == TW'(ACT_TIMEOUT - 1)) begin
            timeout_err     <= 1'b1;
            state           <= FILL;
            bus.price_ready <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state           <= FILL;
          bus.price_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trade_frame_packer.sv
// Directed bench for trade_frame_packer: a SLIDING=0 instance and a
// SLIDING=1 instance, each with its own reset, checked step by step.
module tb_trade_frame_packer;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  logic [4:0] pos0;
  logic [4:0] pos1;
  logic terr0;
  logic terr1;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  trade_frame_packer_if a();
  trade_frame_packer_if b();

  trade_frame_packer #(
    .MAX_POS(31), .POS_W(5), .ACT_TIMEOUT(16), .SLIDING(0)
  ) u0 (
    .clk(clk), .rst(rst0), .bus(a.slave),
    .position(pos0), .timeout_err(terr0)
  );

  trade_frame_packer #(
    .MAX_POS(31), .POS_W(5), .ACT_TIMEOUT(16), .SLIDING(1)
  ) u1 (
    .clk(clk), .rst(rst1), .bus(b.slave),
    .position(pos1), .timeout_err(terr1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send0(input logic [4:0] p);
    a.price_valid = 1'b1;
    a.price_in = p;
    tick();
    a.price_valid = 1'b0;
  endtask

  task automatic hs0();
    a.stock_ready = 1'b1;
    tick();
    a.stock_ready = 1'b0;
  endtask

  task automatic act0(input logic [15:0] c);
    a.action_valid = 1'b1;
    a.action_in = c;
    tick();
    a.action_valid = 1'b0;
  endtask

  task automatic frame0(input logic [15:0] c);
    send0(5'd1);
    send0(5'd2);
    send0(5'd3);
    hs0();
    act0(c);
  endtask

  task automatic send1(input logic [4:0] p);
    b.price_valid = 1'b1;
    b.price_in = p;
    tick();
    b.price_valid = 1'b0;
  endtask

  task automatic hs1();
    b.stock_ready = 1'b1;
    tick();
    b.stock_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a.price_valid = 0; a.price_in = 0; a.stock_ready = 0;
    a.action_valid = 0; a.action_in = 0;
    b.price_valid = 0; b.price_in = 0; b.stock_ready = 0;
    b.action_valid = 0; b.action_in = 0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    tick();
    tick();
    check("rst_stock_out", a.stock_out, 0);
    check("rst_stock_valid", a.stock_valid, 0);
    check("rst_position", pos0, 0);
    check("rst_timeout", terr0, 0);
    check("rst_price_ready", a.price_ready, 1);
    rst0 = 1'b0;
    tick();

    send0(5'd10);
    send0(5'd12);
    check("partial_valid", a.stock_valid, 0);
    send0(5'd15);
    check("f1_valid", a.stock_valid, 1);
    check("f1_word", a.stock_out, 32'h298F);
    check("f1_pready", a.price_ready, 0);
    hs0();
    check("hs_valid", a.stock_valid, 0);
    check("wait_pready", a.price_ready, 0);
    act0(16'd4);
    check("act4_pos", pos0, 4);
    check("act_pready", a.price_ready, 1);

    send0(5'd20);
    send0(5'd18);
    send0(5'd17);
    check("f2_word", a.stock_out, 32'hD251);
    hs0();
    act0(16'd4);
    check("pos8", pos0, 8);
    for (int i = 0; i < 5; i++) frame0(16'd4);
    check("pos28", pos0, 28);
    frame0(16'd3);
    check("pos30", pos0, 30);
    frame0(16'd4);
    check("sat31", pos0, 31);
    frame0(16'd5);
    check("halve15", pos0, 15);
    frame0(16'd0);
    check("code0", pos0, 15);
    frame0(16'd9);
    check("code9", pos0, 15);
    frame0(16'd6);
    check("code6", pos0, 16);
    frame0(16'd8);
    check("code8", pos0, 16);
    frame0(16'd7);
    check("code7", pos0, 17);
    frame0(16'd2);
    check("code2", pos0, 17);
    frame0(16'd1);
    check("exit0", pos0, 0);
    frame0(16'd6);
    check("pos1", pos0, 1);

    send0(5'd7);
    send0(5'd8);
    send0(5'd9);
    check("bp_word0", a.stock_out, 32'h9D09);
    a.price_valid = 1'b1;
    a.price_in = 5'd31;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_word", a.stock_out, 32'h9D09);
      check("bp_valid", a.stock_valid, 1);
      check("bp_pready", a.price_ready, 0);
    end
    hs0();
    a.price_valid = 1'b0;

    for (int i = 0; i < 15; i++) tick();
    check("to_pre_err", terr0, 0);
    check("to_pre_pready", a.price_ready, 0);
    tick();
    check("to_err", terr0, 1);
    check("to_pready", a.price_ready, 1);
    check("to_pos", pos0, 1);
    send0(5'd10);
    send0(5'd12);
    send0(5'd15);
    check("post_to_word", a.stock_out, 32'hA98F);
    check("sticky_err", terr0, 1);

    rst1 = 1'b0;
    tick();
    send1(5'd1);
    send1(5'd2);
    send1(5'd3);
    check("s_f1_word", b.stock_out, 32'h0443);
    check("s_f1_valid", b.stock_valid, 1);
    hs1();
    b.action_valid = 1'b1;
    b.action_in = 16'd2;
    tick();
    b.action_valid = 1'b0;
    check("s_pos0", pos1, 0);
    send1(5'd4);
    check("s_f2_valid", b.stock_valid, 1);
    check("s_f2_word", b.stock_out, 32'h0864);
    hs1();
    for (int i = 0; i < 15; i++) tick();
    b.action_valid = 1'b1;
    b.action_in = 16'd6;
    tick();
    b.action_valid = 1'b0;
    check("edge_err", terr1, 0);
    check("edge_pos", pos1, 1);
    check("edge_pready", b.price_ready, 1);
    send1(5'd5);
    check("s_f3_word", b.stock_out, 32'h8C85);
    check("s_f3_valid", b.stock_valid, 1);

    rst1 = 1'b1;
    #1;
    check("mid_rst_valid", b.stock_valid, 0);
    check("mid_rst_word", b.stock_out, 0);
    check("mid_rst_pos", pos1, 0);
    check("mid_rst_pready", b.price_ready, 1);
    tick();
    rst1 = 1'b0;
    send1(5'd6);
    send1(5'd7);
    check("refill_valid", b.stock_valid, 0);
    send1(5'd8);
    check("refill_word", b.stock_out, 32'h18E8);
    check("refill_done", b.stock_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
